// File: rtl/kalman_pkg.sv
// kalman_pkg: shared types and constants for the Kalman update sequencer.
//   seq_state_t : sequencer FSM states
//   AXIS_RP     : axis tag for a roll/pitch pass
//   AXIS_YAW    : axis tag for a yaw pass
package kalman_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START_RP,
        START_YAW,
        RUN,
        DONE,
        ABORT
    } seq_state_t;

    localparam logic AXIS_RP  = 1'b0;
    localparam logic AXIS_YAW = 1'b1;

endpackage

// File: rtl/flex_counter.sv
// flex_counter: generic up-counter with synchronous clear and programmable
// rollover value.
//   clk, n_rst    : clock, asynchronous active-low reset
//   clear         : synchronous clear to 0 (highest priority)
//   count_enable  : increment when high
//   rollover_val  : last value before the count wraps back to 1
//   count_out     : current count
//   rollover_flag : high while count_out equals rollover_val
module flex_counter #(
    parameter int NUM_CNT_BITS = 4
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    clear,
    input  logic                    count_enable,
    input  logic [NUM_CNT_BITS-1:0] rollover_val,
    output logic [NUM_CNT_BITS-1:0] count_out,
    output logic                    rollover_flag
);

    logic [NUM_CNT_BITS-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (count_enable) begin
            if (count_q == rollover_val) begin
                count_d = NUM_CNT_BITS'(1);
            end else begin
                count_d = count_q + NUM_CNT_BITS'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_out     = count_q;
    assign rollover_flag = (count_q == rollover_val);

endmodule

// File: rtl/kalman_sequencer.sv
// kalman_sequencer: arbitrates IMU sample-ready pulses into single-cycle filter
// start pulses, watches each pass with a watchdog, and holds the result
// handshake for the downstream attitude consumer.
//   clk, n_rst        : clock, asynchronous active-low reset
//   ag_ready          : accel/gyro sample pulse (requests a roll/pitch pass)
//   mag_ready         : magnetometer sample pulse (requests a yaw pass)
//   kalman_done       : pass-complete pulse from the filter timer
//   out_ack           : downstream accepts the held result
//   err_clr           : clears the sticky error flags
//   clear             : timer/datapath clear strobe
//   roll_pitch_enable : roll/pitch pass start pulse
//   yaw_enable        : yaw pass start pulse
//   load_samples      : latch sensor registers into the filter inputs
//   result_valid      : result held until out_ack
//   result_axis       : axis of the held result (0 roll/pitch, 1 yaw)
//   busy              : high whenever not IDLE
//   overrun_err       : sticky, a request arrived while already pending
//   timeout_err       : sticky, a pass was aborted by the watchdog
//   pass_count        : completed passes, wrapping
module kalman_sequencer
    import kalman_pkg::*;
#(
    parameter int TIMEOUT  = 80,
    parameter int CNT_BITS = 8
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic                ag_ready,
    input  logic                mag_ready,
    input  logic                kalman_done,
    input  logic                out_ack,
    input  logic                err_clr,
    output logic                clear,
    output logic                roll_pitch_enable,
    output logic                yaw_enable,
    output logic                load_samples,
    output logic                result_valid,
    output logic                result_axis,
    output logic                busy,
    output logic                overrun_err,
    output logic                timeout_err,
    output logic [CNT_BITS-1:0] pass_count
);

    localparam int                 WD_BITS = 7;
    localparam logic [WD_BITS-1:0] WD_LAST = WD_BITS'(TIMEOUT - 1);

    seq_state_t          state_q, state_d;
    logic                pend_rp_q, pend_rp_d;
    logic                pend_yaw_q, pend_yaw_d;
    logic                overrun_q, overrun_d;
    logic                timeout_q, timeout_d;
    logic                axis_q, axis_d;
    logic [CNT_BITS-1:0] pass_count_q, pass_count_d;

    logic                in_start_rp, in_start_yaw;
    logic                overrun_set, timeout_set;
    logic                wd_clear, wd_enable, wd_expired;
    logic [WD_BITS-1:0]  wd_count;
    logic                wd_count_unused;

    // The watchdog's rollover value is the abort threshold, so its flag is
    // exactly the "watchdog == TIMEOUT-1" condition during RUN.
    flex_counter #(
        .NUM_CNT_BITS (WD_BITS)
    ) u_watchdog (
        .clk           (clk),
        .n_rst         (n_rst),
        .clear         (wd_clear),
        .count_enable  (wd_enable),
        .rollover_val  (WD_LAST),
        .count_out     (wd_count),
        .rollover_flag (wd_expired)
    );

    assign wd_count_unused = ^wd_count;

    always_comb begin
        state_d           = state_q;
        axis_d            = axis_q;
        pass_count_d      = pass_count_q;
        clear             = 1'b0;
        roll_pitch_enable = 1'b0;
        yaw_enable        = 1'b0;
        load_samples      = 1'b0;
        result_valid      = 1'b0;
        result_axis       = 1'b0;
        busy              = (state_q != IDLE);
        wd_clear          = 1'b0;
        wd_enable         = 1'b0;

        in_start_rp  = (state_q == START_RP);
        in_start_yaw = (state_q == START_YAW);

        // A new pulse wins over the clear in the flag's own START cycle.
        pend_rp_d  = ag_ready  | (pend_rp_q  & ~in_start_rp);
        pend_yaw_d = mag_ready | (pend_yaw_q & ~in_start_yaw);

        overrun_set = (ag_ready  & pend_rp_q  & ~in_start_rp) |
                      (mag_ready & pend_yaw_q & ~in_start_yaw);
        timeout_set = (state_q == ABORT);

        overrun_d = overrun_set | (overrun_q & ~err_clr);
        timeout_d = timeout_set | (timeout_q & ~err_clr);

        case (state_q)
            IDLE: begin
                if (pend_rp_q) begin
                    state_d = START_RP;
                end else if (pend_yaw_q) begin
                    state_d = START_YAW;
                end
            end
            START_RP: begin
                clear             = 1'b1;
                load_samples      = 1'b1;
                roll_pitch_enable = 1'b1;
                axis_d            = AXIS_RP;
                wd_clear          = 1'b1;
                state_d           = RUN;
            end
            START_YAW: begin
                clear        = 1'b1;
                load_samples = 1'b1;
                yaw_enable   = 1'b1;
                axis_d       = AXIS_YAW;
                wd_clear     = 1'b1;
                state_d      = RUN;
            end
            RUN: begin
                wd_enable = 1'b1;
                if (kalman_done) begin
                    state_d      = DONE;
                    pass_count_d = pass_count_q + CNT_BITS'(1);
                end else if (wd_expired) begin
                    state_d = ABORT;
                end
            end
            DONE: begin
                result_valid = 1'b1;
                result_axis  = axis_q;
                if (out_ack) begin
                    state_d = IDLE;
                end
            end
            ABORT: begin
                clear   = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        overrun_err = overrun_q;
        timeout_err = timeout_q;
        pass_count  = pass_count_q;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q      <= IDLE;
            pend_rp_q    <= 1'b0;
            pend_yaw_q   <= 1'b0;
            overrun_q    <= 1'b0;
            timeout_q    <= 1'b0;
            axis_q       <= AXIS_RP;
            pass_count_q <= '0;
        end else begin
            state_q      <= state_d;
            pend_rp_q    <= pend_rp_d;
            pend_yaw_q   <= pend_yaw_d;
            overrun_q    <= overrun_d;
            timeout_q    <= timeout_d;
            axis_q       <= axis_d;
            pass_count_q <= pass_count_d;
        end
    end

endmodule

// File: tb/tb_kalman_sequencer.sv
// tb_kalman_sequencer: directed scenarios plus randomized traffic, every cycle
// compared against a pass-level reference model of the sequencer.
module tb_kalman_sequencer;

    localparam int TIMEOUT  = 80;
    localparam int CNT_BITS = 8;

    logic                clk = 1'b0;
    logic                n_rst = 1'b0;
    logic                ag_ready = 1'b0;
    logic                mag_ready = 1'b0;
    logic                kalman_done = 1'b0;
    logic                out_ack = 1'b0;
    logic                err_clr = 1'b0;
    logic                clear;
    logic                roll_pitch_enable;
    logic                yaw_enable;
    logic                load_samples;
    logic                result_valid;
    logic                result_axis;
    logic                busy;
    logic                overrun_err;
    logic                timeout_err;
    logic [CNT_BITS-1:0] pass_count;

    always #5 clk = ~clk;

    kalman_sequencer #(
        .TIMEOUT  (TIMEOUT),
        .CNT_BITS (CNT_BITS)
    ) dut (
        .clk               (clk),
        .n_rst             (n_rst),
        .ag_ready          (ag_ready),
        .mag_ready         (mag_ready),
        .kalman_done       (kalman_done),
        .out_ack           (out_ack),
        .err_clr           (err_clr),
        .clear             (clear),
        .roll_pitch_enable (roll_pitch_enable),
        .yaw_enable        (yaw_enable),
        .load_samples      (load_samples),
        .result_valid      (result_valid),
        .result_axis       (result_axis),
        .busy              (busy),
        .overrun_err       (overrun_err),
        .timeout_err       (timeout_err),
        .pass_count        (pass_count)
    );

    int errors = 0;
    int checks = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: a pass is either being launched, running for some
    // number of cycles, waiting for ack, or being aborted; otherwise idle.
    bit m_pend_rp, m_pend_yaw, m_ovr, m_tmo;
    bit m_start, m_result, m_abort, m_axis;
    int m_run_age;
    int m_cnt;

    function automatic void model_reset();
        m_pend_rp = 0; m_pend_yaw = 0; m_ovr = 0; m_tmo = 0;
        m_start = 0; m_result = 0; m_abort = 0; m_axis = 0;
        m_run_age = -1;
        m_cnt = 0;
    endfunction

    function automatic logic [31:0] model_outs();
        bit busy_e = m_start || (m_run_age >= 0) || m_result || m_abort;
        logic [7:0] cnt8 = 8'(m_cnt % (1 << CNT_BITS));
        return {15'b0, m_start || m_abort, m_start && !m_axis, m_start && m_axis, m_start,
                m_result, m_result && m_axis, busy_e, m_ovr, m_tmo, cnt8};
    endfunction

    function automatic logic [31:0] dut_outs();
        return {15'b0, clear, roll_pitch_enable, yaw_enable, load_samples,
                result_valid, result_axis, busy, overrun_err, timeout_err, pass_count};
    endfunction

    function automatic void model_step(input bit ag, input bit mag, input bit done,
                                       input bit ack, input bit clr);
        bit launch_rp  = m_start && !m_axis;
        bit launch_yaw = m_start && m_axis;
        bit ovr_set    = (ag && m_pend_rp && !launch_rp) || (mag && m_pend_yaw && !launch_yaw);
        bit tmo_set    = m_abort;
        bit want_rp    = m_pend_rp;
        bit want_yaw   = m_pend_yaw;
        m_pend_rp  = ag  || (m_pend_rp  && !launch_rp);
        m_pend_yaw = mag || (m_pend_yaw && !launch_yaw);
        if (m_start) begin
            m_start   = 0;
            m_run_age = 0;
        end else if (m_run_age >= 0) begin
            if (done) begin
                m_run_age = -1;
                m_result  = 1;
                m_cnt     = (m_cnt + 1) % (1 << CNT_BITS);
            end else if (m_run_age == TIMEOUT - 1) begin
                m_run_age = -1;
                m_abort   = 1;
            end else begin
                m_run_age++;
            end
        end else if (m_result) begin
            if (ack) m_result = 0;
        end else if (m_abort) begin
            m_abort = 0;
        end else if (want_rp) begin
            m_start = 1; m_axis = 0;
        end else if (want_yaw) begin
            m_start = 1; m_axis = 1;
        end
        m_ovr = ovr_set || (m_ovr && !clr);
        m_tmo = tmo_set || (m_tmo && !clr);
    endfunction

    // One clock cycle: check current outputs, apply inputs, advance model.
    task automatic cycle(input bit ag, input bit mag, input bit done, input bit ack, input bit clr);
        check_val("outs", dut_outs(), model_outs());
        ag_ready    = ag;
        mag_ready   = mag;
        kalman_done = done;
        out_ack     = ack;
        err_clr     = clr;
        model_step(ag, mag, done, ack, clr);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        n_rst       = 1'b0;
        ag_ready    = 1'b0;
        mag_ready   = 1'b0;
        kalman_done = 1'b0;
        out_ack     = 1'b0;
        err_clr     = 1'b0;
        model_reset();
        #1;
        check_val("reset_outs", dut_outs(), 32'h0);
        repeat (2) @(posedge clk);
        #1;
        check_val("reset_hold", dut_outs(), 32'h0);
        n_rst = 1'b1;
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int pc_before;
        int ack_c;
        int yaw_cnt;
        int acks;
        int enables;
        logic [CNT_BITS-1:0] pc_exp;
        logic axes[$];

        model_reset();
        @(posedge clk);
        #1;
        do_reset();

        // Basic roll/pitch pass with the documented cycle numbering.
        for (int c = 0; c < 82; c++) begin
            if (c == 11) check_val("rp_en_c11", {29'b0, clear, roll_pitch_enable, load_samples}, 32'h0);
            if (c == 12) check_val("rp_start_c12", {29'b0, clear, roll_pitch_enable, load_samples}, 32'h7);
            if (c == 13) check_val("rp_en_c13", {29'b0, clear, roll_pitch_enable, load_samples}, 32'h0);
            if (c == 76) check_val("rv_c76", result_valid, 0);
            if (c == 77) check_val("rv_axis_c77", {result_valid, result_axis}, 2'b10);
            if (c == 80) check_val("busy_c80", busy, 1);
            if (c == 81) begin
                check_val("busy_c81", busy, 0);
                check_val("count_c81", pass_count, 1);
            end
            cycle(c == 10, 0, c == 76, c == 80, 0);
        end

        // Simultaneous requests: roll/pitch first, yaw starts 2 cycles after ack.
        ack_c = -100;
        yaw_cnt = 0;
        for (int c = 0; c < 120; c++) begin
            if (yaw_enable) begin
                yaw_cnt++;
                check_val("yaw_after_ack", c - ack_c, 2);
            end
            if (m_result) begin
                axes.push_back(result_axis);
                if (ack_c < 0) ack_c = c;
            end
            cycle(c == 0, c == 0, m_run_age == 5, m_result, 0);
        end
        check_val("arb_passes", axes.size(), 2);
        if (axes.size() == 2) begin
            check_val("arb_first_axis", axes[0], 0);
            check_val("arb_second_axis", axes[1], 1);
        end
        check_val("arb_yaw_count", yaw_cnt, 1);
        check_val("arb_no_overrun", overrun_err, 0);

        // Two magnetometer pulses during a roll/pitch pass.
        yaw_cnt = 0;
        for (int c = 0; c < 150; c++) begin
            if (yaw_enable) yaw_cnt++;
            cycle(c == 0, (c == 20) || (c == 30), m_run_age == 40, m_result, 0);
        end
        check_val("ovr_set", overrun_err, 1);
        check_val("ovr_one_yaw", yaw_cnt, 1);
        cycle(0, 0, 0, 0, 1);
        check_val("ovr_cleared", overrun_err, 0);

        // Watchdog abort.
        pc_before = m_cnt;
        pc_exp = CNT_BITS'(pc_before);
        for (int c = 0; c < 90; c++) begin
            if (c == 82) check_val("abort_c82", {30'b0, clear, busy}, 32'h1);
            if (c == 83) check_val("abort_c83", {30'b0, clear, busy}, 32'h3);
            if (c == 84) begin
                check_val("abort_idle", busy, 0);
                check_val("abort_tmo", timeout_err, 1);
                check_val("abort_count", pass_count, pc_exp);
            end
            cycle(c == 0, 0, 0, 0, 0);
        end

        // kalman_done on the exact timeout cycle wins.
        cycle(0, 0, 0, 0, 1);
        check_val("tmo_cleared", timeout_err, 0);
        pc_exp = CNT_BITS'(pc_before + 1);
        for (int c = 0; c < 90; c++) begin
            if (c == 83) check_val("edge_done_rv", result_valid, 1);
            if (c == 86) begin
                check_val("edge_done_tmo", timeout_err, 0);
                check_val("edge_done_count", pass_count, pc_exp);
            end
            cycle(c == 0, 0, c == 82, c == 85, 0);
        end

        // Reset in the middle of a pass with a yaw request pending.
        for (int c = 0; c < 20; c++) cycle(c == 0, c == 10, 0, 0, 0);
        check_val("pre_reset_busy", busy, 1);
        do_reset();
        enables = 0;
        for (int c = 0; c < 40; c++) begin
            if (roll_pitch_enable || yaw_enable) enables++;
            cycle(0, 0, 0, 0, 0);
        end
        check_val("post_reset_no_enable", enables, 0);

        // 256 passes wrap the counter back to 0.
        acks = 0;
        for (int c = 0; c < 4000 && acks < 256; c++) begin
            if (m_result) acks++;
            cycle(1, 0, m_run_age == 2, m_result, 0);
        end
        check_val("wrap_passes", acks, 256);
        check_val("wrap_count", pass_count, 0);
        for (int c = 0; c < 20; c++) cycle(0, 0, m_run_age == 2, m_result, 1);

        // Randomized traffic, including stray done/ack outside their states.
        for (int c = 0; c < 3000; c++) begin
            cycle($urandom % 16 == 0, $urandom % 20 == 0, $urandom % 40 == 0,
                  $urandom % 3 == 0, $urandom % 100 == 0);
        end
        check_val("final_outs", dut_outs(), model_outs());

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/kalman_sequencer.md
Name: kalman_sequencer

Overview:
- Top-level update sequencer for the Kalman filter datapath. It sits directly upstream of the filter timer.
- Collects sample-ready pulses from the IMU interface: accel/gyro drives roll/pitch, magnetometer drives yaw.
- Arbitrates them and issues the single-cycle start pulses (clear, roll_pitch_enable, yaw_enable) that launch a filter pass.
- Consumes kalman_done, guards each pass with a watchdog, and presents a held result_valid/out_ack handshake to the downstream attitude consumer.

Parameters:
- TIMEOUT, 80, cycles allowed in RUN before a pass is aborted. Must exceed the timer period of 64; legal range 2..127.
- CNT_BITS, 8, width of the completed-pass counter.

Ports:
- clk  in  1  system clock
- n_rst  in  1  asynchronous active-low reset
- ag_ready  in  1  pulse: new accel/gyro sample available
- mag_ready  in  1  pulse: new magnetometer sample available
- kalman_done  in  1  pulse from filter timer: pass complete
- out_ack  in  1  downstream accepts the current result
- err_clr  in  1  clears the sticky error flags
- clear  out  1  timer/datapath clear strobe
- roll_pitch_enable  out  1  start roll/pitch pass (1-cycle pulse)
- yaw_enable  out  1  start yaw pass (1-cycle pulse)
- load_samples  out  1  strobe: latch sensor registers into filter inputs
- result_valid  out  1  result available; held until out_ack
- result_axis  out  1  0 = roll/pitch, 1 = yaw; valid while result_valid is high
- busy  out  1  high in every state except IDLE
- overrun_err  out  1  sticky: a ready pulse arrived while the same request was already pending
- timeout_err  out  1  sticky: a pass was aborted by the watchdog
- pass_count  out  CNT_BITS  completed passes, wraps modulo 2^CNT_BITS

Behaviour:
- Reset (n_rst low): state IDLE; pend_rp = 0, pend_yaw = 0, watchdog = 0, pass_count = 0, both error flags = 0, axis register = 0. All outputs are 0.
- Reset asserted mid-pass aborts immediately. There is no clear pulse on reset exit.
- Pending flags:
  - ag_ready sets pend_rp; mag_ready sets pend_yaw.
  - A flag clears in its START cycle.
  - If a ready pulse coincides with its own START cycle, set wins and the flag stays 1.
  - A ready pulse while its flag is already 1, and not in that flag's START cycle, sets the matching overrun_err. The request is not queued twice.
- Error flags: overrun_err and timeout_err stay high until err_clr. If err_clr and a new error occur in the same cycle, the error is set (set wins).
- States (Moore outputs, decoded from state):
  - IDLE: if pend_rp, go to START_RP; else if pend_yaw, go to START_YAW. Roll/pitch has fixed priority.
  - START_RP: clear = 1, load_samples = 1, roll_pitch_enable = 1; axis register = 0; watchdog = 0; go to RUN. Lasts exactly 1 cycle.
  - START_YAW: same as START_RP but with yaw_enable = 1 and axis register = 1.
  - RUN:
    - Watchdog increments each cycle.
    - If kalman_done, go to DONE and increment pass_count.
    - Else if watchdog == TIMEOUT-1, go to ABORT.
    - kalman_done in the same cycle as the timeout wins.
  - DONE: result_valid = 1 and result_axis = axis register. If out_ack, go to IDLE; otherwise hold.
  - ABORT: clear = 1, timeout_err set; go to IDLE. Lasts 1 cycle. pass_count is not incremented.
- kalman_done is ignored in every state except RUN.
- out_ack is ignored outside DONE.
- Latency:
  - A ready pulse in cycle N while IDLE gives its enable pulse in cycle N+2.
  - kalman_done in cycle M gives result_valid in cycle M+1.
  - out_ack in DONE returns the block to IDLE at the next edge. The earliest next START is 2 cycles after the ack cycle.
- Pending requests are preserved across passes and across ABORT.

Decomposition:
- Shared package kalman_pkg holds:
  - the sequencer state enum (IDLE, START_RP, START_YAW, RUN, DONE, ABORT);
  - axis constants AXIS_RP = 0 and AXIS_YAW = 1.
- One sub-module is natural: reuse the existing flex_counter for the watchdog, with NUM_CNT_BITS = 7, count_enable driven in RUN, and clear driven in the START states.
- The pending/error flags and pass counter stay inline.

Test Plan:
- Reset, then ag_ready pulse at cycle 10 → roll_pitch_enable, clear and load_samples all high in cycle 12 only. kalman_done at 76 → result_valid from 77 with result_axis = 0. out_ack at 80 → busy low at 81; pass_count = 1.
- ag_ready and mag_ready in the same cycle while IDLE → roll/pitch pass runs first. After its ack, yaw_enable fires 2 cycles later and result_axis = 1 at its completion.
- mag_ready twice during a running roll/pitch pass → overrun_err = 1; exactly one yaw pass follows. err_clr pulse → overrun_err = 0 the next cycle.
- Start a pass with kalman_done never asserted → ABORT at RUN cycle 80 (TIMEOUT = 80): clear pulse, timeout_err = 1, pass_count unchanged, return to IDLE.
- kalman_done on the exact timeout cycle → DONE, timeout_err stays 0. Also run 256 passes → pass_count wraps to 0.
- n_rst low while in RUN with pend_yaw = 1 → all outputs 0, pending flags cleared. No enable pulse after release until a new ready pulse arrives.
